// File: rtl/sobel_window_3x3.sv
// Sobel 3x3 window builder: two line buffers plus a 3x3 shift window, one window per accepted pixel.
// Optional macro SOBEL_WINDOW_FRAME_DONE_EN adds frame_done_o for the last window of each frame.
module sobel_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         pixel_i,
    output logic [DATA_WIDTH-1:0]         d0_o,
    output logic [DATA_WIDTH-1:0]         d1_o,
    output logic [DATA_WIDTH-1:0]         d2_o,
    output logic [DATA_WIDTH-1:0]         d3_o,
    output logic [DATA_WIDTH-1:0]         d4_o,
    output logic [DATA_WIDTH-1:0]         d5_o,
    output logic [DATA_WIDTH-1:0]         d6_o,
    output logic [DATA_WIDTH-1:0]         d7_o,
    output logic [DATA_WIDTH-1:0]         d8_o,
    output logic                          done_o,
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    output logic                          frame_done_o,
`endif
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic                  last_col;
    logic                  last_row;
    logic                  win_hit;

    logic [DATA_WIDTH-1:0] line0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] top_new;
    logic [DATA_WIDTH-1:0] mid_new;

    logic [DATA_WIDTH-1:0] win [9];
    logic                  win_rdy;
    logic                  frame_last;

    assign last_col = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_q == RW'(IMG_HEIGHT - 1));
    assign win_hit  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign top_new  = line1[col_q];
    assign mid_new  = line0[col_q];
    assign col_o    = col_q;
    assign row_o    = row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (valid_i) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Line memories are never cleared; the row counter keeps stale lines out of any emitted window.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            line1[col_q] <= line0[col_q];
            line0[col_q] <= pixel_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
            win_rdy    <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            win_rdy    <= valid_i && win_hit;
            frame_last <= valid_i && last_row && last_col;
            if (valid_i) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= top_new;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= mid_new;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pixel_i;
            end
        end
    end

    // Output stage: window is published one edge after the accepting edge and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_o <= 1'b0;
            d0_o   <= '0;
            d1_o   <= '0;
            d2_o   <= '0;
            d3_o   <= '0;
            d4_o   <= '0;
            d5_o   <= '0;
            d6_o   <= '0;
            d7_o   <= '0;
            d8_o   <= '0;
        end else begin
            done_o <= win_rdy;
            if (win_rdy) begin
                d0_o <= win[0];
                d1_o <= win[1];
                d2_o <= win[2];
                d3_o <= win[3];
                d4_o <= win[4];
                d5_o <= win[5];
                d6_o <= win[6];
                d7_o <= win[7];
                d8_o <= win[8];
            end
        end
    end

`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= win_rdy && frame_last;
        end
    end
`else
    logic unused_frame_last;
    assign unused_frame_last = frame_last;
`endif

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Randomized self-checking bench for sobel_window_3x3 against a 2-D image reference model.
module tb_sobel_window_3x3;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] pixel_i = '0;
    logic [DW-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic          done_o;
    logic [$clog2(W)-1:0] col_o;
    logic [$clog2(H)-1:0] row_o;
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
    logic          frame_done_o;
`endif

    sobel_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pixel_i(pixel_i),
        .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o), .d3_o(d3_o), .d4_o(d4_o),
        .d5_o(d5_o), .d6_o(d6_o), .d7_o(d7_o), .d8_o(d8_o),
        .done_o(done_o),
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
        .frame_done_o(frame_done_o),
`endif
        .col_o(col_o), .row_o(row_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    logic [DW-1:0] dv [9];
    assign dv[0] = d0_o; assign dv[1] = d1_o; assign dv[2] = d2_o;
    assign dv[3] = d3_o; assign dv[4] = d4_o; assign dv[5] = d5_o;
    assign dv[6] = d6_o; assign dv[7] = d7_o; assign dv[8] = d8_o;

    // Reference model: image kept as a 2-D array, window read straight from it.
    logic [DW-1:0]   img [H][W];
    int              mr, mc;
    logic            stg1, stg2, fst1, fst2;
    logic [9*DW-1:0] wq [$];
    logic [9*DW-1:0] held;
    int              npulse;

    function automatic logic [9*DW-1:0] model_window(input int r, input int c, input logic [DW-1:0] p);
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) w[k*DW +: DW] = p;
            else        w[k*DW +: DW] = img[r - 2 + k / 3][c - 2 + k % 3];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mr   <= 0;
            mc   <= 0;
            stg1 <= 1'b0;
            stg2 <= 1'b0;
            fst1 <= 1'b0;
            fst2 <= 1'b0;
            wq.delete();
        end else begin
            stg2 <= stg1;
            fst2 <= fst1;
            if (valid_i) begin
                img[mr][mc] <= pixel_i;
                if (mr >= 2 && mc >= 2) wq.push_back(model_window(mr, mc, pixel_i));
                stg1 <= (mr >= 2 && mc >= 2);
                fst1 <= (mr == H - 1 && mc == W - 1);
                mc   <= (mc == W - 1) ? 0 : mc + 1;
                mr   <= (mc == W - 1) ? ((mr == H - 1) ? 0 : mr + 1) : mr;
            end else begin
                stg1 <= 1'b0;
                fst1 <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("col", 32'(col_o), 32'(mc));
            check("row", 32'(row_o), 32'(mr));
            check("done", 32'(done_o), 32'(stg2));
`ifdef SOBEL_WINDOW_FRAME_DONE_EN
            check("frame_done", 32'(frame_done_o), 32'(fst2));
`endif
            if (stg2 && wq.size() != 0) begin
                held = wq.pop_front();
                npulse++;
            end
            for (int k = 0; k < 9; k++) check("d", 32'(dv[k]), 32'(held[k*DW +: DW]));
        end else begin
            held = '0;
        end
    end

    task automatic send(input logic [DW-1:0] p);
        @(posedge clk); #1;
        valid_i = 1'b1;
        pixel_i = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            pixel_i = DW'($urandom);
        end
    endtask

    logic [DW-1:0] last_win [9];

    initial begin
        npulse = 0;
        held   = '0;
        for (int k = 0; k < 9; k++) last_win[k] = DW'(7 + 5 * (k / 3) + k % 3);
        #12 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) check("reset_d", 32'(dv[k]), 0);
        check("reset_done", 32'(done_o), 0);

        // Continuous frame, pixel = row*5+col
        npulse = 0;
        for (int i = 0; i < W * H; i++) send(DW'(i));
        idle(3);
        check("pulses_frame", 32'(npulse), 6);
        for (int k = 0; k < 9; k++) check("last_window", 32'(dv[k]), 32'(last_win[k]));

        // Same frame with toggling valid and a 3-cycle gap at the last column
        npulse = 0;
        for (int i = 0; i < W * H; i++) begin
            send(DW'(i));
            if (i % 2 == 0) idle(1);
            if (i % W == W - 1) idle(3);
        end
        idle(3);
        check("pulses_gaps", 32'(npulse), 6);

        // Two frames back to back, second offset by 100
        npulse = 0;
        for (int i = 0; i < W * H; i++) send(DW'(i));
        for (int i = 0; i < W * H; i++) send(DW'(100 + i));
        idle(3);
        check("pulses_two_frames", 32'(npulse), 12);

        // Asynchronous reset right after pixel 14 is accepted
        for (int i = 0; i < 15; i++) send(DW'(i));
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("pre_reset_done", 32'(done_o), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_done", 32'(done_o), 0);
        for (int k = 0; k < 9; k++) check("async_d", 32'(dv[k]), 0);
        #3 rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < W * H; i++) send(DW'(i));
        idle(3);
        check("pulses_after_reset", 32'(npulse), 6);
        for (int k = 0; k < 9; k++) check("last_window_rst", 32'(dv[k]), 32'(last_win[k]));

        // Random pixels with random stalls over several frames
        npulse = 0;
        for (int i = 0; i < 3 * W * H; i++) begin
            send(DW'($urandom));
            if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 4));
        end
        idle(3);
        check("pulses_random", 32'(npulse), 18);
        check("queue_drained", 32'(wq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Upstream neighbour of the Sobel calculation stage.
- Accepts a raster-order 8-bit grayscale pixel stream and buffers the two previous image lines in internal line memories.
- Emits each complete 3x3 neighbourhood as nine parallel pixels (d0_o..d8_o) with a one-cycle done_o strobe per window.
- done_o drives the Sobel stage's done_i directly; d*_o drive its d*_i.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- DATA_WIDTH, 8, bits per pixel

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- valid_i  input  1  pixel_i is valid this cycle; one pixel accepted per asserted cycle
- pixel_i  input  DATA_WIDTH  grayscale pixel, raster order (left to right, top to bottom)
- d0_o..d8_o  output  DATA_WIDTH each  window: d0 d1 d2 = top (oldest) row, d3 d4 d5 = middle, d6 d7 d8 = bottom (current) row; left column oldest
- done_o  output  1  one-cycle strobe, d0_o..d8_o hold a new valid window
- col_o  output  clog2(IMG_WIDTH)  column index of the next pixel to be accepted (debug/verification)
- row_o  output  clog2(IMG_HEIGHT)  row index of the next pixel to be accepted

Behaviour:
- Reset (rst_n low, async): col/row counters = 0, done_o = 0, d0_o..d8_o = 0, window shift registers = 0. Line memory contents are not cleared; counters restarting at row 0 makes stale data unreachable.
- Storage:
  - Two line buffers, each IMG_WIDTH x DATA_WIDTH, read/written at address col.
  - On an accepted pixel: line1[col] <= line0[col]; line0[col] <= pixel_i.
  - line0 holds row r-1, line1 holds row r-2.
- Window shift, per accepted pixel only:
  - Each row's three registers shift left: left <= mid, mid <= right.
  - New right column: top <= line1[col], middle <= line0[col], bottom <= pixel_i.
- Counters, per accepted pixel only:
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1, both wrap to 0. Next pixel starts a new frame with no gap or flush needed.
- Window validity:
  - A window is valid when the accepted pixel has row >= 2 and col >= 2, i.e. a window centred on (row-1, col-1).
  - No border padding: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - Windows never straddle a line wrap: col>=2 guarantees all three columns come from the same line.
- Latency: done_o asserts on the clock edge after the accepting edge, with d*_o registered on that same edge (1-cycle latency).
- done_o is low in any cycle with no newly completed window.
- Stall: while valid_i = 0, counters, line buffers and d*_o hold; done_o = 0. Arbitrary gaps, including mid-line, must produce identical windows.
- Back-to-back valid_i: one window per cycle once row >= 2, col >= 2. No backpressure; the block always accepts.
- Reset mid-frame: outputs clear immediately. The first pixel after release is treated as row 0, col 0, and no window is emitted until row 2, col 2 of the new frame.
- Pixel arithmetic: none. Pixels pass through unmodified at DATA_WIDTH.

Optional Feature:
- Macro: SOBEL_WINDOW_FRAME_DONE_EN
- Defined:
  - Adds output frame_done_o (1 bit, reset 0).
  - frame_done_o pulses for one cycle, coincident with done_o, for the last window of a frame (accepted pixel at row IMG_HEIGHT-1, col IMG_WIDTH-1).
- Not defined: port absent, no associated logic.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*5+col, continuous valid_i unless stated):
- Reset then full frame -> first done_o one cycle after pixel 12 with d0..d8 = 0,1,2,5,6,7,10,11,12; exactly 6 done_o pulses in total; last window d0..d8 = 7,8,9,12,13,14,17,18,19.
- Same frame with valid_i toggled 1-0-1 and a 3-cycle gap at col 4 -> identical 6 windows in the same order; done_o never high during gap cycles; d*_o stable during gaps.
- Two frames back-to-back (second frame values +100) -> no window spans frames; 12 pulses total; first window of frame 2 = 100,101,102,105,106,107,110,111,112.
- rst_n pulled low asynchronously after pixel 14 (mid-edge, between clocks) -> d*_o and done_o go to 0 without a clock edge. Restarting the frame from pixel 0 yields the same 6 windows as the first test.
- Pixels at rows 0-1 or cols 0-1 -> done_o stays 0; col_o/row_o step 0..4 / 0..3 and wrap to 0/0 after pixel 19.
- With SOBEL_WINDOW_FRAME_DONE_EN -> frame_done_o high only in the cycle of the 6th done_o pulse.
